ext_mem_arbiter: RTL and testbench

EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

---
 rtl/ext_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ext_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter granting N client ports bursts on one external memory port.
// Latency: grant is combinational in Idle; done pulses the cycle after the last beat.
// Backpressure: ext_mem_full stalls write beats and clears port_ready; ena low freezes everything.
module ext_mem_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 5,
   parameter int ADDR_STEP = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          req_we,
   input  logic [NUM_PORTS*LEN_W-1:0]    req_len_minus1,
   input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
   output logic [NUM_PORTS-1:0]          grant,
   output logic [NUM_PORTS-1:0]          busy_port,
   input  logic [NUM_PORTS-1:0]          port_wr,
   input  logic [NUM_PORTS*DATA_W-1:0]   port_d,
   input  logic [NUM_PORTS-1:0]          port_rd,
   output logic [NUM_PORTS-1:0]          port_ready,
   output logic [NUM_PORTS-1:0]          port_valid,
   output logic [DATA_W-1:0]             port_q,
   output logic [NUM_PORTS-1:0]          done,
   input  logic                          ext_mem_init_done,
   output logic                          ext_mem_burst,
   output logic [LEN_W-1:0]              ext_mem_burst_len_minus1,
   output logic [ADDR_W-1:0]             ext_mem_addr,
   output logic                          ext_mem_rd,
   output logic                          ext_mem_wr,
   output logic [DATA_W-1:0]             ext_mem_d,
   input  logic [DATA_W-1:0]             ext_mem_q,
   input  logic                          ext_mem_full,
   input  logic                          ext_mem_valid
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [IDX_W-1:0]   win_idx;
   logic               win_vld;
   logic               grant_ok;
   int                 scan_idx;
   int                 own_i;
   int                 win_i;

   assign own_i  = int'(owner_q);
   assign win_i  = int'(win_idx);
   assign port_q = ext_mem_q;

   // Round-robin search: first requester after the last winner, wrapping around.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      scan_idx = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         scan_idx = int'(rr_ptr_q) + k;
         if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
         if (!win_vld && req[scan_idx]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(scan_idx);
         end
      end
   end

   // Grant pulses are suppressed while frozen or held in reset.
   assign grant_ok = ena & rst_n & ext_mem_init_done & win_vld;

   // Burst FSM next-state and output decode.
   always_comb begin
      state_d                  = state_q;
      rr_ptr_d                 = rr_ptr_q;
      owner_d                  = owner_q;
      len_d                    = len_q;
      cnt_d                    = cnt_q;
      addr_d                   = addr_q;
      grant                    = '0;
      busy_port                = '0;
      port_ready               = '0;
      port_valid               = '0;
      done                     = '0;
      ext_mem_burst            = 1'b0;
      ext_mem_burst_len_minus1 = len_q;
      ext_mem_addr             = addr_q;
      ext_mem_rd               = 1'b0;
      ext_mem_wr               = 1'b0;
      ext_mem_d                = port_d[own_i*DATA_W +: DATA_W];
      case (state_q)
         ST_IDLE: begin
            if (grant_ok) begin
               grant[win_idx]           = 1'b1;
               ext_mem_burst            = 1'b1;
               ext_mem_burst_len_minus1 = req_len_minus1[win_i*LEN_W +: LEN_W];
               ext_mem_addr             = req_addr[win_i*ADDR_W +: ADDR_W];
               rr_ptr_d                 = win_idx;
               owner_d                  = win_idx;
               len_d                    = req_len_minus1[win_i*LEN_W +: LEN_W];
               addr_d                   = req_addr[win_i*ADDR_W +: ADDR_W];
               cnt_d                    = '0;
               state_d                  = req_we[win_idx] ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            busy_port[owner_q]  = 1'b1;
            port_ready[owner_q] = ~ext_mem_full;
            // A beat only moves when the memory can take it and the block is running.
            if (ena && port_wr[owner_q] && !ext_mem_full) begin
               ext_mem_wr = 1'b1;
               addr_d     = addr_q + ADDR_W'(ADDR_STEP);
               cnt_d      = cnt_q + LEN_W'(1);
               if (cnt_q == len_q) state_d = ST_DONE;
            end
         end
         ST_READ: begin
            busy_port[owner_q]  = 1'b1;
            port_ready[owner_q] = ~ext_mem_full;
            if (ena) begin
               ext_mem_rd          = port_rd[owner_q];
               port_valid[owner_q] = ext_mem_valid;
               // Address follows issued strobes; the beat count follows returned data.
               if (port_rd[owner_q]) addr_d = addr_q + ADDR_W'(ADDR_STEP);
               if (ext_mem_valid) begin
                  cnt_d = cnt_q + LEN_W'(1);
                  if (cnt_q == len_q) state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (ena) begin
               done[owner_q] = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers: synchronous reset, frozen while ena is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= IDX_W'(NUM_PORTS - 1);
         owner_q  <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
      end else if (ena) begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
      end
   end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter with a transaction-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
// Memory-side full/valid and client strobes are randomized per cycle.
module tb_ext_mem_arbiter;

   localparam int N    = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LW   = 5;
   localparam int STEP = 4;

   logic              clk = 1'b0;
   logic              rst_n, ena;
   logic [N-1:0]      req, req_we;
   logic [N*LW-1:0]   req_len_minus1;
   logic [N*AW-1:0]   req_addr;
   logic [N-1:0]      grant, busy_port;
   logic [N-1:0]      port_wr, port_rd, port_ready, port_valid, done;
   logic [N*DW-1:0]   port_d;
   logic [DW-1:0]     port_q;
   logic              ext_mem_init_done, ext_mem_burst, ext_mem_rd, ext_mem_wr;
   logic [LW-1:0]     ext_mem_burst_len_minus1;
   logic [AW-1:0]     ext_mem_addr;
   logic [DW-1:0]     ext_mem_d, ext_mem_q;
   logic              ext_mem_full, ext_mem_valid;

   int total = 0;
   int bad   = 0;

   // Reference model state: last winner plus the attributes each port asked for.
   int            rr_m;
   logic          m_we   [N];
   logic [LW-1:0] m_len  [N];
   logic [AW-1:0] m_addr [N];

   ext_mem_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ADDR_STEP(STEP)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .req(req), .req_we(req_we), .req_len_minus1(req_len_minus1), .req_addr(req_addr),
      .grant(grant), .busy_port(busy_port),
      .port_wr(port_wr), .port_d(port_d), .port_rd(port_rd),
      .port_ready(port_ready), .port_valid(port_valid), .port_q(port_q), .done(done),
      .ext_mem_init_done(ext_mem_init_done), .ext_mem_burst(ext_mem_burst),
      .ext_mem_burst_len_minus1(ext_mem_burst_len_minus1), .ext_mem_addr(ext_mem_addr),
      .ext_mem_rd(ext_mem_rd), .ext_mem_wr(ext_mem_wr), .ext_mem_d(ext_mem_d),
      .ext_mem_q(ext_mem_q), .ext_mem_full(ext_mem_full), .ext_mem_valid(ext_mem_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1);
   end

   // Next winner: first requesting port strictly after the previous winner, modulo N.
   function automatic int exp_winner(input logic [N-1:0] r, input int ptr);
      for (int k = 1; k <= N; k++)
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic set_req(input int p, input logic we, input logic [LW-1:0] len, input logic [AW-1:0] a);
      req[p]                    = 1'b1;
      req_we[p]                 = we;
      req_len_minus1[p*LW +: LW] = len;
      req_addr[p*AW +: AW]       = a;
      m_we[p]   = we;
      m_len[p]  = len;
      m_addr[p] = a;
   endtask

   task automatic quiet_inputs();
      port_wr = '0; port_rd = '0; ext_mem_full = 1'b0; ext_mem_valid = 1'b0;
   endtask

   // Runs one complete burst: waits for the model's winner, drives beats, checks done.
   // full_mode: 0 never full, 1 random full, 2 full on beat cycles 2 and 3 with wr always on.
   task automatic drive_burst(input int full_mode, input bit pause_done, output int got, output int wait_cyc);
      int ew, beats, cyc;
      logic [N-1:0]  oh;
      logic [AW-1:0] ea;
      logic [LW-1:0] ln;
      logic          we, fl, exp_wr;
      ew = exp_winner(req, rr_m);
      got = -1;
      wait_cyc = -1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         ext_mem_init_done = 1'b1; ena = 1'b1;
         #1;
         if (grant !== '0) begin wait_cyc = c; break; end
      end
      total++;
      if (wait_cyc < 0 || ew < 0) begin
         bad++; $display("FAIL grant_wait got=none exp=port%0d", ew);
         return;
      end
      for (int k = 0; k < N; k++) if (grant[k]) got = k;
      oh = '0; oh[ew] = 1'b1;
      total++; if (grant !== oh) begin bad++; $display("FAIL grant_onehot got=%b exp=%b", grant, oh); end
      total++; if (ext_mem_burst !== 1'b1) begin bad++; $display("FAIL burst_pulse got=%b exp=1", ext_mem_burst); end
      total++; if (ext_mem_addr !== m_addr[ew]) begin bad++; $display("FAIL grant_addr got=%h exp=%h", ext_mem_addr, m_addr[ew]); end
      total++; if (ext_mem_burst_len_minus1 !== m_len[ew]) begin bad++; $display("FAIL grant_len got=%0d exp=%0d", ext_mem_burst_len_minus1, m_len[ew]); end
      total++; if (done !== '0) begin bad++; $display("FAIL grant_done got=%b exp=0", done); end
      rr_m = ew; ea = m_addr[ew]; ln = m_len[ew]; we = m_we[ew];
      beats = 0;
      for (cyc = 1; beats <= int'(ln) && cyc < 200; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) req[ew] = 1'b0;
         case (full_mode)
            0:       fl = 1'b0;
            1:       fl = ($urandom_range(0, 3) == 0);
            default: fl = (cyc == 2 || cyc == 3);
         endcase
         ext_mem_full      = fl;
         ext_mem_init_done = 1'($urandom_range(0, 1));
         port_wr           = N'($urandom);
         if (full_mode == 2) port_wr[ew] = 1'b1;
         port_rd           = N'($urandom);
         port_d            = {$urandom, $urandom, $urandom, $urandom};
         ext_mem_valid     = 1'($urandom_range(0, 1));
         ext_mem_q         = $urandom;
         #1;
         total++; if (busy_port !== oh) begin bad++; $display("FAIL busy got=%b exp=%b", busy_port, oh); end
         total++; if (port_ready !== (fl ? '0 : oh)) begin bad++; $display("FAIL ready got=%b exp=%b", port_ready, fl ? '0 : oh); end
         total++; if (grant !== '0 || ext_mem_burst !== 1'b0 || done !== '0) begin
            bad++; $display("FAIL no_preempt got=grant%b burst%b done%b exp=0", grant, ext_mem_burst, done); end
         total++; if (ext_mem_burst_len_minus1 !== ln) begin bad++; $display("FAIL held_len got=%0d exp=%0d", ext_mem_burst_len_minus1, ln); end
         if (we) begin
            exp_wr = port_wr[ew] & ~fl;
            total++; if (ext_mem_wr !== exp_wr || ext_mem_rd !== 1'b0) begin
               bad++; $display("FAIL wr_strobe got=wr%b rd%b exp=wr%b rd0", ext_mem_wr, ext_mem_rd, exp_wr); end
            total++; if (port_valid !== '0) begin bad++; $display("FAIL wr_valid got=%b exp=0", port_valid); end
            if (exp_wr) begin
               total++; if (ext_mem_addr !== ea) begin bad++; $display("FAIL wr_addr got=%h exp=%h", ext_mem_addr, ea); end
               total++; if (ext_mem_d !== port_d[ew*DW +: DW]) begin bad++; $display("FAIL wr_data got=%h exp=%h", ext_mem_d, port_d[ew*DW +: DW]); end
               ea = ea + AW'(STEP);
               beats++;
            end
         end else begin
            total++; if (ext_mem_rd !== port_rd[ew] || ext_mem_wr !== 1'b0) begin
               bad++; $display("FAIL rd_strobe got=rd%b wr%b exp=rd%b wr0", ext_mem_rd, ext_mem_wr, port_rd[ew]); end
            if (port_rd[ew]) begin
               total++; if (ext_mem_addr !== ea) begin bad++; $display("FAIL rd_addr got=%h exp=%h", ext_mem_addr, ea); end
               ea = ea + AW'(STEP);
            end
            total++; if (port_valid !== (ext_mem_valid ? oh : '0)) begin
               bad++; $display("FAIL rd_valid got=%b exp=%b", port_valid, ext_mem_valid ? oh : '0); end
            total++; if (port_q !== ext_mem_q) begin bad++; $display("FAIL rd_data got=%h exp=%h", port_q, ext_mem_q); end
            if (ext_mem_valid) beats++;
         end
      end
      total++; if (beats <= int'(ln)) begin bad++; $display("FAIL beat_budget got=%0d exp=%0d", beats, ln + 1); end
      if (pause_done) begin
         for (int p = 0; p < 2; p++) begin
            @(posedge clk); #1;
            quiet_inputs(); ena = 1'b0;
            #1;
            total++; if (done !== '0 || grant !== '0) begin bad++; $display("FAIL frozen_done got=done%b grant%b exp=0", done, grant); end
         end
      end
      @(posedge clk); #1;
      quiet_inputs(); ena = 1'b1; ext_mem_init_done = 1'b1;
      #1;
      total++; if (done !== oh) begin bad++; $display("FAIL done_pulse got=%b exp=%b", done, oh); end
      total++; if (busy_port !== '0 || grant !== '0) begin bad++; $display("FAIL done_idle got=busy%b grant%b exp=0", busy_port, grant); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; req = '1; req_we = '0; req_len_minus1 = '0; req_addr = '1;
      port_wr = '1; port_rd = '1; port_d = '1; ext_mem_q = '1;
      ext_mem_init_done = 1'b1; ext_mem_full = 1'b0; ext_mem_valid = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      total++; if (grant !== '0) begin bad++; $display("FAIL rst_grant got=%b exp=0", grant); end
      total++; if (busy_port !== '0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_port); end
      total++; if (done !== '0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      total++; if (port_ready !== '0) begin bad++; $display("FAIL rst_ready got=%b exp=0", port_ready); end
      total++; if (port_valid !== '0) begin bad++; $display("FAIL rst_valid got=%b exp=0", port_valid); end
      total++; if (ext_mem_burst !== 1'b0) begin bad++; $display("FAIL rst_burst got=%b exp=0", ext_mem_burst); end
      total++; if (ext_mem_rd !== 1'b0 || ext_mem_wr !== 1'b0) begin bad++; $display("FAIL rst_rdwr got=%b%b exp=00", ext_mem_rd, ext_mem_wr); end
      total++; if (ext_mem_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h exp=0", ext_mem_addr); end
      total++; if (ext_mem_burst_len_minus1 !== '0) begin bad++; $display("FAIL rst_len got=%0d exp=0", ext_mem_burst_len_minus1); end
      req = '0; quiet_inputs(); rst_n = 1'b1;
      rr_m = N - 1;
   endtask

   task automatic test_rr_order();
      int got, wc;
      for (int p = 0; p < N; p++) set_req(p, 1'(p % 2), LW'(p), 32'h1000 * (p + 1));
      for (int i = 0; i < N; i++) begin
         drive_burst(1, 1'b0, got, wc);
         total++; if (got !== i) begin bad++; $display("FAIL rr_order got=%0d exp=%0d", got, i); end
      end
   endtask

   task automatic test_write_full();
      int got, wc;
      set_req(2, 1'b1, LW'(3), 32'h100);
      drive_burst(2, 1'b0, got, wc);
      total++; if (got !== 2) begin bad++; $display("FAIL wfull_port got=%0d exp=2", got); end
   endtask

   task automatic test_read8();
      int got, wc;
      set_req(1, 1'b0, LW'(7), 32'h2000);
      drive_burst(0, 1'b0, got, wc);
      total++; if (got !== 1) begin bad++; $display("FAIL read8_port got=%0d exp=1", got); end
   endtask

   task automatic test_init_done();
      int got, wc;
      ext_mem_init_done = 1'b0;
      set_req(0, 1'b1, LW'(0), 32'h40);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #2;
         total++; if (grant !== '0) begin bad++; $display("FAIL init_block got=%b exp=0", grant); end
      end
      drive_burst(0, 1'b0, got, wc);
      total++; if (wc !== 0) begin bad++; $display("FAIL init_latency got=%0d exp=0", wc); end
   endtask

   task automatic test_addr_wrap();
      int got, wc;
      set_req(3, 1'b1, LW'(1), 32'hFFFF_FFFC);
      drive_burst(1, 1'b0, got, wc);
      total++; if (got !== 3) begin bad++; $display("FAIL wrap_port got=%0d exp=3", got); end
   endtask

   task automatic test_ena();
      int got, wc;
      set_req(2, 1'b0, LW'(2), 32'h800);
      ena = 1'b0;
      #1;
      total++; if (grant !== '0 || ext_mem_burst !== 1'b0) begin bad++; $display("FAIL ena_grant got=%b exp=0", grant); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #2;
         total++; if (grant !== '0 || ext_mem_burst !== 1'b0) begin bad++; $display("FAIL ena_hold got=%b exp=0", grant); end
      end
      drive_burst(1, 1'b1, got, wc);
      total++; if (got !== 2) begin bad++; $display("FAIL ena_port got=%0d exp=2", got); end
   endtask

   task automatic test_back_to_back();
      int got, wc, n;
      logic [N-1:0] mask;
      for (int r = 0; r < 12; r++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         n = 0;
         for (int p = 0; p < N; p++)
            if (mask[p]) begin
               set_req(p, 1'($urandom_range(0, 1)), LW'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC);
               n++;
            end
         for (int b = 0; b < n; b++) begin
            drive_burst(1, (r % 4) == 0, got, wc);
            total++; if (wc !== 1) begin bad++; $display("FAIL b2b_gap got=%0d exp=1", wc); end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int wc;
      set_req(0, 1'b0, LW'(7), 32'h300);
      wc = -1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         #1;
         if (grant !== '0) begin wc = c; break; end
      end
      total++; if (wc < 0) begin bad++; $display("FAIL mid_grant got=none exp=port0"); end
      for (int b = 1; b <= 3; b++) begin
         @(posedge clk); #1;
         req = '0; port_rd = 4'b0001; ext_mem_valid = 1'b1; ext_mem_q = $urandom;
         if (b == 3) rst_n = 1'b0;
      end
      @(posedge clk); #1;
      req = '1;
      #1;
      total++; if ({grant, busy_port, done, port_ready, port_valid} !== '0) begin
         bad++; $display("FAIL mid_ports got=%b exp=0", {grant, busy_port, done, port_ready, port_valid}); end
      total++; if ({ext_mem_burst, ext_mem_rd, ext_mem_wr} !== 3'b000) begin
         bad++; $display("FAIL mid_mem got=%b exp=000", {ext_mem_burst, ext_mem_rd, ext_mem_wr}); end
      total++; if (ext_mem_addr !== '0 || ext_mem_burst_len_minus1 !== '0) begin
         bad++; $display("FAIL mid_regs got=%h/%0d exp=0/0", ext_mem_addr, ext_mem_burst_len_minus1); end
      @(posedge clk); #1;
      req = '0; quiet_inputs(); rst_n = 1'b1;
      #1;
      total++; if (done !== '0 || busy_port !== '0) begin bad++; $display("FAIL mid_nodone got=%b/%b exp=0", done, busy_port); end
      rr_m = N - 1;
   endtask

   initial begin
      test_reset();
      test_rr_order();
      test_write_full();
      test_read8();
      test_init_done();
      test_addr_wrap();
      test_ena();
      test_back_to_back();
      test_reset_mid_burst();
      test_rr_order();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
